// File: rtl/memory_stage.sv
// Pipeline MEM stage: issues one data-bus request per aligned load/store,
// stalls execute until the response arrives, aligns and extends load data.

package common;
    typedef logic [63:0] u64;
    typedef logic [31:0] u32;
    typedef logic [4:0]  creg_addr_t;
    typedef logic [2:0]  msize_t;
endpackage

package pipes;
    import common::*;

    typedef enum logic [2:0] {
        ALU    = 3'd0,
        LOAD   = 3'd1,
        STORE  = 3'd2,
        BRANCH = 3'd3,
        JUMP   = 3'd4
    } op_t;

    typedef struct packed {
        op_t    op;
        msize_t msize;
        logic   unsigned_ld;
        logic   regwrite;
    } control_t;

    typedef struct packed {
        logic       valid;
        u64         pc;
        u32         instr;
        control_t   ctl;
        creg_addr_t dst;
        u64         rd2;
        u64         result;
    } excute_data_t;

    typedef struct packed {
        logic       valid;
        u64         pc;
        u32         instr;
        control_t   ctl;
        creg_addr_t dst;
        u64         result;
        u64         addr;
    } memory_data_t;
endpackage

module memory_stage
    import pipes::*;
(
    input  logic         clk,
    input  logic         reset,
    input  excute_data_t dataE,
    output memory_data_t dataM,
    output logic         stopm,
    output logic         dreq_valid,
    output logic [63:0]  dreq_addr,
    output logic [2:0]   dreq_size,
    output logic [7:0]   dreq_strobe,
    output logic [63:0]  dreq_data,
    input  logic         dresp_data_ok,
    input  logic [63:0]  dresp_data,
    output logic         misalign
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state;
    logic [2:0]  off;
    logic [5:0]  lane_shift;
    logic [7:0]  size_mask;
    logic [2:0]  align_mask;
    logic        is_load;
    logic        is_store;
    logic        mem_op;
    logic        misaligned;
    logic        aligned_mem_op;
    logic        bad_mem_op;
    logic [63:0] shifted;
    logic [63:0] load_val;

    assign off        = dataE.result[2:0];
    assign lane_shift = {off, 3'b000};
    assign is_load    = (dataE.ctl.op == LOAD);
    assign is_store   = (dataE.ctl.op == STORE);
    assign mem_op     = dataE.valid & (is_load | is_store);

    always_comb begin
        size_mask  = 8'hFF;
        align_mask = 3'b111;
        case (dataE.ctl.msize)
            3'd0: begin size_mask = 8'h01; align_mask = 3'b000; end
            3'd1: begin size_mask = 8'h03; align_mask = 3'b001; end
            3'd2: begin size_mask = 8'h0F; align_mask = 3'b011; end
            default: begin size_mask = 8'hFF; align_mask = 3'b111; end
        endcase
    end

    assign misaligned     = |(off & align_mask);
    assign aligned_mem_op = mem_op & ~misaligned;
    assign bad_mem_op     = mem_op & misaligned;

    assign stopm       = aligned_mem_op & ~dresp_data_ok;
    // BUSY keeps the request up even if the held instruction were disturbed
    assign dreq_valid  = aligned_mem_op | (state == BUSY);
    assign dreq_addr   = {dataE.result[63:3], 3'b000};
    assign dreq_size   = dataE.ctl.msize;
    assign dreq_strobe = (aligned_mem_op & is_store) ? (size_mask << off) : '0;
    assign dreq_data   = dataE.rd2 << lane_shift;

    assign shifted = dresp_data >> lane_shift;

    always_comb begin
        load_val = shifted;
        case (dataE.ctl.msize)
            3'd0: load_val = dataE.ctl.unsigned_ld ? {56'd0, shifted[7:0]}
                                                   : {{56{shifted[7]}}, shifted[7:0]};
            3'd1: load_val = dataE.ctl.unsigned_ld ? {48'd0, shifted[15:0]}
                                                   : {{48{shifted[15]}}, shifted[15:0]};
            3'd2: load_val = dataE.ctl.unsigned_ld ? {32'd0, shifted[31:0]}
                                                   : {{32{shifted[31]}}, shifted[31:0]};
            default: load_val = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            dataM    <= '0;
            misalign <= 1'b0;
        end else begin
            misalign <= bad_mem_op;

            case (state)
                IDLE: if (aligned_mem_op && !dresp_data_ok) state <= BUSY;
                BUSY: if (dresp_data_ok) state <= IDLE;
                default: state <= IDLE;
            endcase

            // Fields are copied every cycle; only valid decides whether it counts
            dataM.valid  <= dataE.valid & ~stopm & ~bad_mem_op;
            dataM.pc     <= dataE.pc;
            dataM.instr  <= dataE.instr;
            dataM.ctl    <= dataE.ctl;
            dataM.dst    <= dataE.dst;
            dataM.result <= (aligned_mem_op & is_load) ? load_val : dataE.result;
            dataM.addr   <= dataE.result;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Randomised bench for memory_stage: acts as execute stage and data bus,
// checking against a byte-level reference model.

module tb_memory_stage;
    import pipes::*;

    logic         clk;
    logic         reset;
    excute_data_t data_e;
    memory_data_t data_m;
    logic         stopm;
    logic         dreq_valid;
    logic [63:0]  dreq_addr;
    logic [2:0]   dreq_size;
    logic [7:0]   dreq_strobe;
    logic [63:0]  dreq_data;
    logic         dresp_data_ok;
    logic [63:0]  dresp_data;
    logic         misalign;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    memory_stage dut (
        .clk          (clk),
        .reset        (reset),
        .dataE        (data_e),
        .dataM        (data_m),
        .stopm        (stopm),
        .dreq_valid   (dreq_valid),
        .dreq_addr    (dreq_addr),
        .dreq_size    (dreq_size),
        .dreq_strobe  (dreq_strobe),
        .dreq_data    (dreq_data),
        .dresp_data_ok(dresp_data_ok),
        .dresp_data   (dresp_data),
        .misalign     (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_load(input logic [63:0] word, input int unsigned ofs,
                                             input int unsigned n, input bit uns);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = word[8*(ofs+i) +: 8];
        if (!uns && n < 8 && v[8*n-1])
            for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [7:0] ref_strobe(input int unsigned ofs, input int unsigned n);
        logic [7:0] s = '0;
        for (int i = 0; i < n; i++) s[ofs+i] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] ref_wdata(input logic [63:0] rd2, input int unsigned ofs);
        logic [63:0] d = '0;
        for (int i = ofs; i < 8; i++) d[8*i +: 8] = rd2[8*(i-ofs) +: 8];
        return d;
    endfunction

    // Entered and left at posedge+1: presents one instruction and plays the bus.
    task automatic issue(input logic v, input op_t op, input logic [2:0] msize, input logic uns,
                         input logic [63:0] res, input logic [63:0] rd2, input int unsigned waits,
                         input logic [63:0] rdata, input logic [4:0] dst);
        int unsigned n    = 1 << msize;
        int unsigned ofs  = res[2:0];
        bit is_mem = v && (op == LOAD || op == STORE);
        bit mis    = is_mem && (ofs % n != 0);
        bit go     = is_mem && !mis;
        int unsigned last = go ? waits : 0;
        logic [63:0] pc = {$urandom, $urandom};
        logic [63:0] exp_res;

        data_e.valid           = v;
        data_e.pc              = pc;
        data_e.instr           = $urandom;
        data_e.ctl.op          = op;
        data_e.ctl.msize       = msize;
        data_e.ctl.unsigned_ld = uns;
        data_e.ctl.regwrite    = 1'b1;
        data_e.dst             = dst;
        data_e.rd2             = rd2;
        data_e.result          = res;
        dresp_data             = rdata;

        for (int c = 0; c <= last; c++) begin
            dresp_data_ok = go ? (c == last) : 1'($urandom % 2);
            #3;
            check_eq("stopm", 64'(stopm), 64'(go && c < last));
            check_eq("dreq_valid", 64'(dreq_valid), 64'(go));
            if (go) begin
                check_eq("dreq_addr", dreq_addr, {res[63:3], 3'b000});
                check_eq("dreq_size", 64'(dreq_size), 64'(msize));
                check_eq("dreq_strobe", 64'(dreq_strobe),
                         64'(op == STORE ? ref_strobe(ofs, n) : 8'h00));
                if (op == STORE) check_eq("dreq_data", dreq_data, ref_wdata(rd2, ofs));
            end else begin
                check_eq("dreq_strobe_idle", 64'(dreq_strobe), 64'd0);
            end
            @(posedge clk); #1;
            if (c < last) begin
                check_eq("stall_bubble", 64'(data_m.valid), 64'd0);
                check_eq("stall_misalign", 64'(misalign), 64'd0);
            end
        end

        exp_res = (go && op == LOAD) ? ref_load(rdata, ofs, n, uns) : res;
        check_eq("m_valid", 64'(data_m.valid), 64'(v && !mis));
        check_eq("misalign", 64'(misalign), 64'(mis));
        if (v && !mis) begin
            check_eq("m_result", data_m.result, exp_res);
            check_eq("m_addr", data_m.addr, res);
            check_eq("m_pc", data_m.pc, pc);
            check_eq("m_dst", 64'(data_m.dst), 64'(dst));
        end
        dresp_data_ok = 1'b0;
    endtask

    initial begin
        reset         = 1'b0;
        data_e        = '0;
        dresp_data_ok = 1'b0;
        dresp_data    = '0;
        #12;
        check_eq("rst_dataM", 64'(data_m.valid) | data_m.result | data_m.addr | data_m.pc, 64'd0);
        check_eq("rst_misalign", 64'(misalign), 64'd0);
        check_eq("rst_stopm", 64'(stopm), 64'd0);
        check_eq("rst_dreq_valid", 64'(dreq_valid), 64'd0);
        check_eq("rst_strobe", 64'(dreq_strobe), 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        issue(1, ALU, 0, 0, 64'h1234, 64'h0, 0, 64'h0, 5);
        check_eq("alu_result", data_m.result, 64'h1234);
        issue(1, LOAD, 0, 0, 64'h1003, 64'h0, 3, 64'h00000000_80000000, 6);
        check_eq("lb_result", data_m.result, 64'hFFFF_FFFF_FFFF_FF80);
        issue(1, STORE, 1, 0, 64'h2006, 64'hABCD, 0, 64'h0, 0);
        issue(1, LOAD, 2, 1, 64'h3004, 64'h0, 1, 64'hF00D_BEEF_0000_0000, 7);
        check_eq("lwu_result", data_m.result, 64'h0000_0000_F00D_BEEF);
        issue(1, LOAD, 3, 0, 64'h4004, 64'h0, 0, 64'h0, 8);
        issue(1, ALU, 0, 0, 64'h55, 64'h0, 0, 64'h0, 9);

        // Reset while a load is outstanding
        data_e.valid     = 1'b1;
        data_e.ctl.op    = LOAD;
        data_e.ctl.msize = 3'd3;
        data_e.result    = 64'h5008;
        dresp_data_ok    = 1'b0;
        #3;
        check_eq("busy_req", 64'(dreq_valid), 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check_eq("rst_busy_dataM", 64'(data_m.valid) | data_m.result | data_m.addr, 64'd0);
        data_e.valid = 1'b0;
        #1;
        check_eq("rst_busy_dreq", 64'(dreq_valid), 64'd0);
        check_eq("rst_busy_stopm", 64'(stopm), 64'd0);
        @(posedge clk); #1;
        reset         = 1'b1;
        dresp_data_ok = 1'b1;
        #3;
        check_eq("late_ok_dreq", 64'(dreq_valid), 64'd0);
        check_eq("late_ok_stopm", 64'(stopm), 64'd0);
        @(posedge clk); #1;
        check_eq("late_ok_valid", 64'(data_m.valid), 64'd0);
        dresp_data_ok = 1'b0;
        issue(1, LOAD, 1, 0, 64'h6002, 64'h0, 1, 64'h0000_0000_8001_0000, 3);
        check_eq("lh_after_rst", data_m.result, 64'hFFFF_FFFF_FFFF_8001);

        for (int k = 0; k < 300; k++) begin
            op_t op;
            case ($urandom % 5)
                0: op = ALU;
                1, 2: op = LOAD;
                3: op = STORE;
                default: op = BRANCH;
            endcase
            issue(1'($urandom % 10 != 0), op, 3'($urandom % 4), 1'($urandom % 2),
                  {$urandom, $urandom}, {$urandom, $urandom}, $urandom % 4,
                  {$urandom, $urandom}, 5'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline MEM stage: consumes the `excute_data_t` register produced by the execute stage. It issues one data-bus request per valid load or store, holds the pipeline via `stopm` until the bus answers, and aligns and extends load data. It registers the result into `memory_data_t` for the writeback stage. Non-memory instructions pass through with one cycle of latency.

## Interface
- No parameters; widths are fixed by the `common`/`pipes` packages.
- `clk`  in  1  pipeline clock, all state on its rising edge.
- `reset`  in  1  asynchronous, active-low; `reset==0` clears all state immediately.
- `dataE`  in  `excute_data_t`  execute register: `valid`, `pc`, `instr`, `ctl`, `dst`, `rd2` (store data), `result` (effective address or ALU value).
- `dataM`  out  `memory_data_t`  registered: `valid`, `pc`, `instr`, `ctl`, `dst`, `result` (load data or passthrough), `addr`.
- `stopm`  out  1  combinational; high means execute must hold `dataE`.
- `dreq_valid`  out  1  data request valid.
- `dreq_addr`  out  64  `{dataE.result[63:3], 3'b000}` (8-byte aligned).
- `dreq_size`  out  3  `ctl.msize`: 0=1B, 1=2B, 2=4B, 3=8B.
- `dreq_strobe`  out  8  byte write enables; 0 for loads.
- `dreq_data`  out  64  store data shifted to lane.
- `dresp_data_ok`  in  1  response/completion strobe.
- `dresp_data`  in  64  read data, aligned to the 8-byte word.
- `misalign`  out  1  registered; pulses for one cycle per misaligned access dropped.

## Operation
- `mem_op = dataE.valid & (ctl.op==LOAD | ctl.op==STORE)`. `off = dataE.result[2:0]`.
- Misaligned means `off` is not a multiple of `1<<msize`.
  - A misaligned `mem_op` issues no request and has no stall.
  - `dataM.valid` is 0 for that instruction; `misalign` is 1 for one cycle.
- Store lanes:
  - `strobe = mask << off`, with `mask` = 8'h01 / 8'h03 / 8'h0F / 8'hFF for msize 0..3.
  - `dreq_data = dataE.rd2 << (8*off)`.
- Load extraction:
  - `raw = dresp_data >> (8*off)`, truncated to the access size.
  - Sign-extend, or zero-extend when `ctl.unsigned_ld` is set, to 64 bits.
- FSM states are IDLE and BUSY.
  - IDLE and aligned `mem_op`: `dreq_valid=1` combinationally from `dataE`.
    - If `dresp_data_ok` is high the same cycle: complete, stay IDLE.
    - Otherwise go to BUSY.
  - BUSY: `dreq_valid=1`, and the request fields stay stable (guaranteed because `dataE` is frozen by `stopm`).
    - On `dresp_data_ok`: complete, go to IDLE.
  - A raised request is never withdrawn before `dresp_data_ok`.
- `stopm = aligned_mem_op & ~dresp_data_ok`, evaluated in both states.
- Completion captures into `dataM` at the next edge:
  - `valid=1`; `result` = extracted load value for loads, `dataE.result` for stores.
  - `addr = dataE.result`.
- Non-memory op: `dataM` takes `dataE` unchanged (`result=dataE.result`) each cycle `stopm==0`.
- While `stopm==1`, `dataM.valid` is written 0. A bubble goes downstream; the same instruction is never emitted twice.
- `dataE.valid==0`: `dataM.valid` is written 0, and the other fields are don't-care (copied).
- A response arriving in IDLE without an outstanding request is ignored.

## Timing
- Reset values:
  - `dataM` all fields 0.
  - State IDLE.
  - `misalign` 0.
  - With `dataE.valid==0`, `stopm`, `dreq_valid`, and `dreq_strobe` are 0.
- Passthrough latency: 1 cycle from `dataE` to `dataM`.
- Memory latency: 1 + (cycles until `dresp_data_ok`). Zero-wait response gives 1 cycle total.
- `stopm` falls in the same cycle `dresp_data_ok` is high. Execute advances at that edge, and `dataM` captures at that same edge.
- Reset asserted mid-request (BUSY) forces IDLE and zeroes `dataM` immediately. The outstanding request is abandoned; the bus side is reset by the same signal.
- Back-to-back memory ops: a new request can be raised the cycle after completion, with no idle gap.

## Test plan
- ALU passthrough:
  - Stimulus: `dataE` valid, op=ALU, `result=64'h1234`, `dst=5`.
  - Required: the next cycle `dataM.valid=1`, `result=64'h1234`, `dst=5`; `stopm` stays 0 and `dreq_valid` stays 0.
- LB sign-extend:
  - Stimulus: `result=64'h1003`, msize=0, signed; the bus returns `64'h00000000_80000000` after 3 wait cycles.
  - Required: `dreq_addr=64'h1000`; `stopm` is high for 3 cycles, then low; `dataM.result=64'hFFFF_FFFF_FFFF_FF80`.
- SH lane:
  - Stimulus: `result=64'h2006`, msize=1, `rd2=64'hABCD`; zero-wait `data_ok`.
  - Required: `strobe=8'hC0`, `dreq_data=64'hABCD_0000_0000_0000`, `stopm` 0; `dataM.valid=1` the next cycle.
- LWU zero-extend:
  - Stimulus: `result=64'h3004`, unsigned; the bus returns `64'hF00D_BEEF_0000_0000`.
  - Required: `dataM.result=64'h0000_0000_F00D_BEEF`.
- Misaligned LD:
  - Stimulus: `result=64'h4004`, msize=3.
  - Required: no `dreq_valid`; `misalign=1` for exactly 1 cycle; `dataM.valid=0`.
- Reset in BUSY:
  - Stimulus: a load outstanding 2 cycles, then `reset` pulled to 0 asynchronously.
  - Required: `dreq_valid` and `stopm` drop (with `dataE` invalid), `dataM` reads 0, and the FSM is in IDLE; a late `data_ok` after release is ignored.
